// File: rtl/mem_byte_bridge.sv
// rtl/mem_byte_bridge.sv - word-bus to byte-wide slave bridge with region decode and read reassembly.
// Optional per-byte timeout when MEM_BYTE_BRIDGE_TIMEOUT_EN is defined.
module mem_byte_bridge #(
  parameter int N_SLAVES = 4,
  parameter int BUS_BYTES = 4,
  parameter logic [32*N_SLAVES-1:0] SLV_BASE = {N_SLAVES{32'h0}},
  parameter logic [32*N_SLAVES-1:0] SLV_MASK = {N_SLAVES{32'h0}},
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [8*BUS_BYTES-1:0] i_bus_data,
  input  logic [31:0]            i_bus_address,
  input  logic                   i_bus_DV,
  input  logic [2:0]             i_bhw,
  input  logic                   i_write_notread,
  output logic [8*BUS_BYTES-1:0] o_bus_data,
  output logic                   o_bus_DV,
  output logic                   o_bus_err,
  output logic                   o_busy,
  output logic [N_SLAVES-1:0]    o_slv_req,
  output logic [31:0]            o_slv_addr,
  output logic [7:0]             o_slv_data,
  output logic                   o_slv_write,
  input  logic [8*N_SLAVES-1:0]  i_slv_data,
  input  logic [N_SLAVES-1:0]    i_slv_done
);

  localparam int IDXW = $clog2(BUS_BYTES) + 1;
  localparam int BW   = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 1;
  localparam int SELW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state, state_nxt;
  logic [31:0]            addr_q;
  logic [8*BUS_BYTES-1:0] data_q, asm_q;
  logic [IDXW-1:0]        idx_q, cnt_q;
  logic [SELW-1:0]        sel_q, hit_idx;
  logic                   write_q, err_q;
  logic                   hit, bad_size, done_sel, last_byte, timeout;
  logic [BW-1:0]          bidx;

  assign bidx      = idx_q[BW-1:0];
  assign done_sel  = i_slv_done[sel_q];
  assign last_byte = (idx_q + IDXW'(1)) == cnt_q;
  assign bad_size  = (i_bhw == 3'd0) || (32'(i_bhw) > 32'(BUS_BYTES));

  // Descending scan so the lowest-index matching region wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if ((i_bus_address & SLV_MASK[32*k +: 32]) == SLV_BASE[32*k +: 32]) begin
        hit     = 1'b1;
        hit_idx = SELW'(k);
      end
    end
  end

`ifdef MEM_BYTE_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q;

  // Fires on the TIMEOUT_CYC-th WAIT cycle; a done in that same cycle still wins.
  assign timeout = !done_sel && (tcnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)            tcnt_q <= '0;
    else if (state == ISSUE) tcnt_q <= '0;
    else if (state == WAIT)  tcnt_q <= tcnt_q + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_bus_DV    = 1'b0;
    o_bus_err   = 1'b0;
    o_bus_data  = '0;
    o_busy      = (state != IDLE);
    o_slv_req   = '0;
    o_slv_addr  = addr_q + 32'(idx_q);
    o_slv_data  = data_q[{bidx, 3'b000} +: 8];
    o_slv_write = write_q;
    case (state)
      IDLE:  if (i_bus_DV) state_nxt = (hit && !bad_size) ? ISSUE : RESP;
      ISSUE: begin
        o_slv_req = N_SLAVES'(1) << sel_q;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (done_sel)     state_nxt = last_byte ? RESP : ISSUE;
        else if (timeout) state_nxt = RESP;
      end
      RESP: begin
        o_bus_DV   = 1'b1;
        o_bus_err  = err_q;
        o_bus_data = (write_q || err_q) ? '0 : asm_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      asm_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_bus_DV) begin
          addr_q  <= i_bus_address;
          data_q  <= i_bus_data;
          cnt_q   <= IDXW'(i_bhw);
          write_q <= i_write_notread;
          asm_q   <= '0;
          idx_q   <= '0;
          sel_q   <= hit_idx;
          err_q   <= !hit || bad_size;
        end
        WAIT: begin
          if (done_sel) begin
            if (!write_q) asm_q[{bidx, 3'b000} +: 8] <= i_slv_data[{sel_q, 3'b000} +: 8];
            idx_q <= idx_q + 1'b1;
          end
`ifdef MEM_BYTE_BRIDGE_TIMEOUT_EN
          else if (timeout) begin
            err_q <= 1'b1;
            asm_q <= '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_byte_bridge.md
Name: mem_byte_bridge

Overview:
- Parametrised successor to the memory-top bus front end.
- Accepts one word-bus transaction (1..BUS_BYTES bytes) from the CPU bus and decodes its base address against N_SLAVES mask/base regions.
- Serialises the transaction into byte requests to the selected byte-wide slave (cache_altera, uart, plic_mem, etc.) and reassembles read data.
- Adds what the previous front end lacks: reset, error response on decode miss or illegal size, per-byte timeout, and a busy flag.

Parameters:
- N_SLAVES, 4, number of byte-wide slave channels.
- BUS_BYTES, 4, bus width in bytes; bus data width is 8*BUS_BYTES.
- SLV_BASE, {N_SLAVES{32'h0}}, flattened 32-bit base per slave; slave k occupies bits [32k+31:32k].
- SLV_MASK, {N_SLAVES{32'h0}}, flattened 32-bit mask per slave; hit when (addr & mask) == base.
- TIMEOUT_CYC, 255, cycles to wait for i_done per byte before aborting (TIMEOUT_EN only).

Ports:
- i_clk  in  1  clock, all logic on the rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_bus_data  in  8*BUS_BYTES  write data; byte k is written to address+k.
- i_bus_address  in  32  transaction base address.
- i_bus_DV  in  1  request strobe; sampled only in IDLE.
- i_bhw  in  3  byte count; legal values are 1..BUS_BYTES.
- i_write_notread  in  1  1 = write, 0 = read.
- o_bus_data  out  8*BUS_BYTES  read data, zero-extended above i_bhw bytes.
- o_bus_DV  out  1  one-cycle completion pulse.
- o_bus_err  out  1  valid with o_bus_DV: decode miss, illegal size, or timeout.
- o_busy  out  1  high whenever the state is not IDLE.
- o_slv_req  out  N_SLAVES  one-hot, one-cycle byte request.
- o_slv_addr  out  32  byte address, shared by all slaves.
- o_slv_data  out  8  write byte, shared.
- o_slv_write  out  1  write flag, shared.
- i_slv_data  in  8*N_SLAVES  read byte from each slave.
- i_slv_done  in  N_SLAVES  per-slave byte-complete pulse.

Behaviour:
- Reset (i_rst_n = 0 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0: o_bus_data, o_bus_DV, o_bus_err, o_busy, o_slv_req, o_slv_addr, o_slv_data, o_slv_write.
  - Byte counter and timeout counter are cleared.
- Reset mid-transaction aborts with no o_bus_DV. A late i_slv_done after reset is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, on i_bus_DV:
  - Latch address, data, i_bhw and direction.
  - Clear the read assembly register.
  - Decode the base address; lowest-index hit wins.
  - On hit: select that slave and go to ISSUE.
  - On miss, or i_bhw = 0, or i_bhw > BUS_BYTES: set the error flag and go to RESP.
- The whole transaction goes to the slave decoded from the base address. Bytes crossing a region boundary are not re-decoded.
- ISSUE:
  - Assert o_slv_req[sel] for exactly one cycle.
  - o_slv_addr = base + byte index.
  - o_slv_data = latched byte[index].
  - Go to WAIT.
- WAIT:
  - On i_slv_done[sel]: for reads, store i_slv_data[sel] into byte[index]; then increment the index.
  - If index + 1 == count, go to RESP; otherwise go back to ISSUE.
  - Done pulses from non-selected slaves are ignored, as is any done pulse seen in ISSUE.
- o_slv_addr, o_slv_data and o_slv_write hold stable from ISSUE through WAIT.
- RESP:
  - o_bus_DV = 1 for one cycle; o_bus_err = error flag.
  - o_bus_data = assembled bytes; 0 on writes and on errors.
  - Go to IDLE.
- i_bus_DV while busy is ignored; it is neither queued nor acknowledged. The bus master must wait for o_bus_DV.
- Latency, for a slave that raises done 1 cycle after req:
  - n-byte transaction: o_bus_DV is asserted 2n+1 cycles after the accept edge.
  - Decode error: o_bus_DV is asserted 1 cycle after the accept edge.
- Address arithmetic is 32-bit modulo; base 32'hFFFF_FFFF + 1 wraps to 0.
- Byte index width is clog2(BUS_BYTES)+1, so no overflow is possible.

Optional Feature:
- Macro: MEM_BYTE_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter clears on every ISSUE and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC without done: set error, clear the assembled data, go to RESP.
  - A done arriving on the same cycle as the timeout wins; the byte completes normally.
- Not defined:
  - No counter is synthesised.
  - WAIT waits indefinitely.
  - o_bus_err covers only decode miss and illegal size.

Test Plan:
- Reset: hold i_rst_n = 0 for 3 cycles during an active WAIT -> all outputs 0, state IDLE, no o_bus_DV; a later stray i_slv_done is ignored.
- Word read: slave1 base 32'h1000, mask 32'hFFFF_F000 returns bytes 11,22,33,44; read addr 32'h1004, i_bhw = 4 ->
  - o_slv_addr sequence 1004..1007;
  - o_bus_data = 32'h4433_2211, o_bus_err = 0;
  - o_bus_DV 9 cycles after accept.
- Halfword write: i_bus_data = 32'hDEAD_BEEF, i_bhw = 2 to slave0 -> o_slv_data EF then BE, o_slv_write = 1, o_bus_data = 0, one o_bus_DV.
- Decode miss: address outside all regions -> no o_slv_req, o_bus_DV and o_bus_err asserted 1 cycle after accept.
- Illegal size: i_bhw = 5 or 0 -> immediate error response; a new i_bus_DV during busy is ignored and a second request after o_bus_DV completes normally.
- Timeout (TIMEOUT_EN, TIMEOUT_CYC = 8): slave never raises done -> o_bus_err = 1 and o_bus_data = 0; done on exactly cycle 8 -> normal completion.
